// File: rtl/apu_frame_counter.sv
// -----------------------------------------------------------------------------
// apu_frame_counter
//
// APU frame sequencer. Divides the APU clock into quarter-frame and half-frame
// strobes for the pulse channels' envelope, length-counter and sweep logic, and
// maintains the frame IRQ flag. Configured from the $4017 value, which is
// qualified by a toggle-style change flag (any level change = register write).
//
// Ports:
//   i_apu_clk      sole clock, all state updates on its rising edge
//   i_rst          asynchronous, active-high reset
//   i_reg_4017     [7] mode (0 = 4-step, 1 = 5-step), [6] IRQ inhibit
//   i_frame_change write toggle; source returns it to 0 on reset
//   i_irq_clear    synchronous level clear of o_frame_irq
//   o_qtr_clk      registered quarter-frame strobe (one cycle)
//   o_hlf_clk      registered half-frame strobe (one cycle)
//   o_frame_irq    registered frame interrupt flag
// -----------------------------------------------------------------------------
module apu_frame_counter #(
   parameter int unsigned STEP1 = 3728,
   parameter int unsigned STEP2 = 7456,
   parameter int unsigned STEP3 = 11185,
   parameter int unsigned STEP4 = 14914,
   parameter int unsigned STEP5 = 18640
) (
   input  logic       i_apu_clk,
   input  logic       i_rst,
   input  logic [7:0] i_reg_4017,
   input  logic       i_frame_change,
   input  logic       i_irq_clear,
   output logic       o_qtr_clk,
   output logic       o_hlf_clk,
   output logic       o_frame_irq
);

   typedef enum logic {
      MODE_4STEP = 1'b0,
      MODE_5STEP = 1'b1
   } mode_t;

   localparam logic [14:0] L_STEP1 = 15'(STEP1);
   localparam logic [14:0] L_STEP2 = 15'(STEP2);
   localparam logic [14:0] L_STEP3 = 15'(STEP3);
   localparam logic [14:0] L_STEP4 = 15'(STEP4);
   localparam logic [14:0] L_STEP5 = 15'(STEP5);

   logic [14:0] r_cnt;
   mode_t       r_mode;
   logic        r_inhibit;
   logic        r_frm_seen;
   logic        r_qtr;
   logic        r_hlf;
   logic        r_irq;

   logic        w_write;
   mode_t       w_new_mode;
   logic        w_at1;
   logic        w_at2;
   logic        w_at3;
   logic        w_at4;
   logic        w_at5;
   logic        w_last;
   logic        w_qtr;
   logic        w_hlf;
   logic        w_irq_set;
   logic        w_unused_bits;

   // Only the mode and inhibit bits of $4017 matter here.
   assign w_unused_bits = ^i_reg_4017[5:0];

   assign w_write    = (i_frame_change != r_frm_seen);
   assign w_new_mode = mode_t'(i_reg_4017[7]);

   always_comb begin
      w_at1     = (r_cnt == L_STEP1);
      w_at2     = (r_cnt == L_STEP2);
      w_at3     = (r_cnt == L_STEP3);
      w_at4     = (r_cnt == L_STEP4);
      w_at5     = (r_cnt == L_STEP5);
      // The final step of the active sequence both wraps the counter and
      // produces the combined quarter+half clock.
      w_last    = (r_mode == MODE_5STEP) ? w_at5 : w_at4;
      w_qtr     = w_at1 | w_at2 | w_at3 | w_last;
      w_hlf     = w_at2 | w_last;
      w_irq_set = (r_mode == MODE_4STEP) & w_at4 & ~r_inhibit;
   end

   always_ff @(posedge i_apu_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_mode     <= MODE_4STEP;
         r_inhibit  <= 1'b0;
         r_frm_seen <= 1'b0;
         r_qtr      <= 1'b0;
         r_hlf      <= 1'b0;
         r_irq      <= 1'b0;
      end else if (w_write) begin
         // A write overrides any step decoded on the same edge. Entering
         // 5-step mode issues an immediate quarter+half clock.
         r_frm_seen <= i_frame_change;
         r_mode     <= w_new_mode;
         r_inhibit  <= i_reg_4017[6];
         r_cnt      <= '0;
         r_qtr      <= (w_new_mode == MODE_5STEP);
         r_hlf      <= (w_new_mode == MODE_5STEP);
         if (i_reg_4017[6] || i_irq_clear) begin
            r_irq <= 1'b0;
         end
      end else begin
         r_cnt <= w_last ? '0 : r_cnt + 15'd1;
         r_qtr <= w_qtr;
         r_hlf <= w_hlf;
         // Setting takes priority over a coincident status-read clear.
         if (w_irq_set) begin
            r_irq <= 1'b1;
         end else if (i_irq_clear) begin
            r_irq <= 1'b0;
         end
      end
   end

   assign o_qtr_clk   = r_qtr;
   assign o_hlf_clk   = r_hlf;
   assign o_frame_irq = r_irq;

endmodule
